stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Control block for the stopwatch. It takes the divided 1 Hz and 1 kHz clocks from the clock divider and operator button pulses. It sequences an mm:ss BCD time counter through idle, running and paused states, and schedules the 4-digit multiplexed 7-segment scan at 1 kHz. It sits between the clock divider and the segment decoder/pad ring.

## Interface
Parameters:
- MAX_MIN_TENS, default 5: largest minutes-tens value before wrap.
- SCAN_DIGITS, default 4: number of multiplexed digits. Fixed at 4; other values are unsupported.

Ports:
- clk_100MHz, input, 1: system clock.
- rst_n, input, 1: reset, synchronous, active-low.
- clk_1Hz, input, 1: divided 1 Hz clock level, synchronous to clk_100MHz.
- clk_1kHz, input, 1: divided 1 kHz clock level, synchronous to clk_100MHz.
- btn_start_stop, input, 1: single-cycle debounced pulse.
- btn_clear, input, 1: single-cycle debounced pulse.
- btn_lap, input, 1: single-cycle debounced pulse.
- running, output, 1: high in RUNNING.
- lap_active, output, 1: display frozen.
- time_bcd, output, 16: live count {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each.
- wrap, output, 1: one-cycle pulse on 59:59 → 00:00.
- digit_sel_n, output, 4: active-low one-hot digit enable; bit 0 is sec_ones.
- digit_val, output, 4: BCD value of the selected displayed digit.

## Operation
- Tick extraction:
  - clk_1Hz and clk_1kHz are each registered once (_q).
  - tick_1s = clk_1Hz & ~clk_1Hz_q; tick_scan = clk_1kHz & ~clk_1kHz_q.
  - No synchronizers are used (same clock domain).
- FSM states: IDLE, RUNNING, PAUSED.
  - IDLE + start_stop → RUNNING.
  - RUNNING + start_stop → PAUSED.
  - PAUSED + start_stop → RUNNING.
  - IDLE/PAUSED + clear → IDLE, counter zeroed, lap_active cleared.
  - RUNNING + clear → ignored.
  - RUNNING + lap → toggle lap_active. When lap_active rises, the live count is copied into the lap register.
  - PAUSED + lap → clears lap_active. IDLE + lap → ignored.
- Simultaneous button events (priority): clear (if legal in the current state) > start_stop > lap. Lower-priority pulses in the same cycle are dropped.
- Counting:
  - Increment only when state is RUNNING and tick_1s is high in the same cycle.
  - A tick in the cycle where start_stop leaves RUNNING is not applied.
  - A tick in the cycle where start_stop enters RUNNING from IDLE/PAUSED is not applied.
- BCD chain:
  - sec_ones 0–9, sec_tens 0–5, min_ones 0–9, min_tens 0–MAX_MIN_TENS.
  - Each digit carries into the next.
  - At MAX:59, the next tick wraps to 00:00, wrap pulses for 1 cycle, and counting continues.
- Display source: lap register when lap_active is high, else the live count.
- Scan:
  - On each tick_scan, the scan index advances 0→1→2→3→0.
  - digit_sel_n = ~(1 << idx).
  - digit_val = displayed digit[idx].
  - Scan runs in all states.

## Timing
- Reset values (rst_n low at a clock edge): state IDLE, running 0, lap_active 0, time_bcd 16'h0000, lap register 0, wrap 0, _q registers 0, scan idx 0, digit_sel_n 4'b1110, digit_val 0.
- Reset mid-count returns to IDLE at 00:00 on the same edge. Button pulses coincident with reset are ignored.
- Counter latency: time_bcd updates on the clock edge of the cycle in which clk_1Hz is first sampled high (1 clock after clk_1Hz rises at the register input).
- Button response: running updates on the edge that samples the button pulse.
- Scan: digit_sel_n/digit_val update on the edge where tick_scan is high.
  - One digit step per 1 ms; full refresh every 4 ms.
  - digit_val and digit_sel_n change on the same edge (no skew).
- All outputs are registered. No combinational path from input to output.

## Structure
- Shared package stopwatch_pkg:
  - state enum (IDLE, RUNNING, PAUSED);
  - bcd_t (logic [3:0]);
  - time_t struct {min_tens, min_ones, sec_tens, sec_ones};
  - constants SEC_ONES_MAX=9, SEC_TENS_MAX=5, MIN_ONES_MAX=9, SCAN_DIGITS=4.
- One sub-module, bcd_time_counter: inputs clk_100MHz, rst_n, clr, inc; outputs time_t and wrap.
- FSM, lap register and scan scheduler stay in stopwatch_ctrl.

## Test plan
- Reset check: reset asserted, then released → digit_sel_n=4'b1110, time_bcd=0000, running=0. Then start_stop followed by 3 clk_1Hz rising edges → time_bcd=16'h0003, running=1.
- Carry and wrap: preload to 59:58 via ticks (or force through the counter), then 2 ticks → 59:59, then 00:00 with wrap high for exactly 1 cycle.
- Pause/resume and tick coincidence: start_stop in the same cycle as tick_1s while RUNNING → PAUSED, count unchanged. Further ticks ignored. start_stop → RUNNING; next tick increments.
- Clear rules:
  - clear while RUNNING at 00:07 → still 00:07 and RUNNING.
  - Pause, then clear → IDLE, 0000.
  - clear and start_stop in the same cycle while PAUSED → IDLE wins.
- Lap freeze: RUNNING at 00:10, lap, then 5 ticks → scanned digits still show 0010 while time_bcd=0015. lap again → display shows 0015.
- Scan rotation: 8 clk_1kHz rising edges → digit_sel_n sequence 1101,1011,0111,1110 repeated, with digit_val matching the displayed digit each step.

Source files
------------

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared types and BCD digit limits for the stopwatch control
//               block and its time counter.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    // Control states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } state_e;

    // One BCD digit
    typedef logic [3:0] bcd_t;

    // mm:ss time value, most significant digit first
    typedef struct packed {
        bcd_t min_tens;
        bcd_t min_ones;
        bcd_t sec_tens;
        bcd_t sec_ones;
    } time_t;

    localparam bcd_t SEC_ONES_MAX = 4'd9;
    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t MIN_ONES_MAX = 4'd9;
    localparam int   SCAN_DIGITS  = 4;

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/stopwatch_ctrl_bcd_time_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_time_counter
// Description : mm:ss BCD counter with synchronous clear, single-step
//               increment and a one-cycle wrap pulse on MAX:59 -> 00:00.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_time_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX_MIN_TENS = 5
) (
    input  logic  clk_100MHz,
    input  logic  rst_n,
    input  logic  clr,
    input  logic  inc,
    output time_t count,
    output logic  wrap
);

    localparam bcd_t MIN_TENS_MAX = bcd_t'(MAX_MIN_TENS);

    time_t count_q, count_d;
    logic  wrap_q,  wrap_d;

    // Ripple the increment through the digit chain; clear has priority
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            if (count_q.sec_ones != SEC_ONES_MAX) begin
                count_d.sec_ones = count_q.sec_ones + 4'd1;
            end else begin
                count_d.sec_ones = '0;
                if (count_q.sec_tens != SEC_TENS_MAX) begin
                    count_d.sec_tens = count_q.sec_tens + 4'd1;
                end else begin
                    count_d.sec_tens = '0;
                    if (count_q.min_ones != MIN_ONES_MAX) begin
                        count_d.min_ones = count_q.min_ones + 4'd1;
                    end else begin
                        count_d.min_ones = '0;
                        if (count_q.min_tens != MIN_TENS_MAX) begin
                            count_d.min_tens = count_q.min_tens + 4'd1;
                        end else begin
                            count_d.min_tens = '0;
                            wrap_d           = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Count and wrap registers
    always_ff @(posedge clk_100MHz) begin
        if (!rst_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule : bcd_time_counter
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Stopwatch sequencer: idle/running/paused control, lap freeze
//               register and 4-digit multiplexed display scan scheduling.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter int MAX_MIN_TENS = 5,
    parameter int SCAN_DIGITS  = stopwatch_pkg::SCAN_DIGITS
) (
    input  logic        clk_100MHz,
    input  logic        rst_n,
    input  logic        clk_1Hz,
    input  logic        clk_1kHz,
    input  logic        btn_start_stop,
    input  logic        btn_clear,
    input  logic        btn_lap,
    output logic        running,
    output logic        lap_active,
    output logic [15:0] time_bcd,
    output logic        wrap,
    output logic [3:0]  digit_sel_n,
    output logic [3:0]  digit_val
);
    import stopwatch_pkg::*;

    localparam int                IDX_W    = $clog2(SCAN_DIGITS);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(SCAN_DIGITS - 1);

    // Divided clocks arrive already in this domain, so a single register
    // per level is enough for rising-edge detection.
    logic clk_1Hz_q;
    logic clk_1kHz_q;
    logic tick_1s;
    logic tick_scan;

    state_e           state_q,       state_d;
    logic             running_q,     running_d;
    logic             lap_active_q,  lap_active_d;
    time_t            lap_q,         lap_d;
    logic [IDX_W-1:0] idx_q,         idx_d;
    logic [3:0]       digit_sel_n_q, digit_sel_n_d;
    logic [3:0]       digit_val_q,   digit_val_d;

    logic             cnt_clr;
    logic             cnt_inc;
    logic             clear_ok;
    time_t            live;
    logic [15:0]      disp_flat;

    assign tick_1s   = clk_1Hz  & ~clk_1Hz_q;
    assign tick_scan = clk_1kHz & ~clk_1kHz_q;

    // Clear is only honoured outside RUNNING, so it cannot mask start_stop there
    assign clear_ok  = btn_clear && (state_q != RUNNING);

    bcd_time_counter #(
        .MAX_MIN_TENS (MAX_MIN_TENS)
    ) u_counter (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .clr        (cnt_clr),
        .inc        (cnt_inc),
        .count      (live),
        .wrap       (wrap)
    );

    // Next state, lap register and counter controls; clear > start_stop > lap
    always_comb begin
        state_d      = state_q;
        lap_active_d = lap_active_q;
        lap_d        = lap_q;
        cnt_clr      = 1'b0;
        // A start_stop pulse in RUNNING always leaves RUNNING, so its
        // coincident second tick is discarded.
        cnt_inc      = (state_q == RUNNING) && tick_1s && !btn_start_stop;

        if (clear_ok) begin
            state_d      = IDLE;
            lap_active_d = 1'b0;
            cnt_clr      = 1'b1;
        end else if (btn_start_stop) begin
            case (state_q)
                RUNNING: state_d = PAUSED;
                default: state_d = RUNNING;
            endcase
        end else if (btn_lap) begin
            case (state_q)
                RUNNING: begin
                    lap_active_d = !lap_active_q;
                    if (!lap_active_q) begin
                        lap_d = live;
                    end
                end
                PAUSED:  lap_active_d = 1'b0;
                default: lap_active_d = lap_active_q;
            endcase
        end

        running_d = (state_d == RUNNING);
    end

    assign disp_flat = lap_active_q ? lap_q : live;

    // Scan scheduler: step the digit index and latch select/value together
    always_comb begin
        idx_d         = idx_q;
        digit_sel_n_d = digit_sel_n_q;
        digit_val_d   = digit_val_q;
        if (tick_scan) begin
            idx_d         = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            digit_sel_n_d = ~(4'b0001 << idx_d);
            digit_val_d   = disp_flat[{idx_d, 2'b00} +: 4];
        end
    end

    // Control, lap and scan registers
    always_ff @(posedge clk_100MHz) begin
        if (!rst_n) begin
            clk_1Hz_q     <= 1'b0;
            clk_1kHz_q    <= 1'b0;
            state_q       <= IDLE;
            running_q     <= 1'b0;
            lap_active_q  <= 1'b0;
            lap_q         <= '0;
            idx_q         <= '0;
            digit_sel_n_q <= 4'b1110;
            digit_val_q   <= 4'd0;
        end else begin
            clk_1Hz_q     <= clk_1Hz;
            clk_1kHz_q    <= clk_1kHz;
            state_q       <= state_d;
            running_q     <= running_d;
            lap_active_q  <= lap_active_d;
            lap_q         <= lap_d;
            idx_q         <= idx_d;
            digit_sel_n_q <= digit_sel_n_d;
            digit_val_q   <= digit_val_d;
        end
    end

    assign running     = running_q;
    assign lap_active  = lap_active_q;
    assign time_bcd    = live;
    assign digit_sel_n = digit_sel_n_q;
    assign digit_val   = digit_val_q;

endmodule : stopwatch_ctrl
`default_nettype wire
